// File: rtl/tiny_rv_fetch_if.sv
// Instruction-memory channel between the fetch stage and instruction memory.
// The request side is valid/ready. The response side is valid-only: memory
// returns exactly one response per accepted request.
interface tiny_rv_fetch_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic [31:0] rsp_data;

    modport master (
        output req_valid,
        output req_addr,
        input  req_ready,
        input  rsp_valid,
        input  rsp_data
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        output req_ready,
        output rsp_valid,
        output rsp_data
    );
endinterface

// File: rtl/tiny_rv_fetch.sv
// tiny_rv instruction fetch stage.
// Keeps the fetch PC and allows one outstanding word request to imem.
// Returned words are buffered in a small FIFO for decode.
// A redirect from execute flushes the FIFO and discards any response that is
// still in flight. A misaligned redirect target becomes a single fault-marker
// entry, and fetch then stalls until the next redirect.
module tiny_rv_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    tiny_rv_fetch_if.master       imem,
    input  logic                  br_taken,
    input  logic [31:0]           br_addr,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           out_pc,
    output logic [31:0]           out_next_pc,
    output logic [31:0]           out_instr,
    output logic                  out_misaligned
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DROP,
        S_FAULT
    } state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        misaligned;
    } entry_t;

    state_t         state, state_n;
    logic [31:0]    fetch_pc, fetch_pc_n;
    // A request that was valid but not yet accepted when a redirect arrived.
    // It stays on the bus, at its original address, until memory accepts it.
    // Its response is then dropped.
    logic           hold, hold_n;
    logic [31:0]    hold_addr, hold_addr_n;
    // A misaligned redirect arrived while a response was still owed.
    // Once that response is discarded, the next state is FAULT.
    logic           fault_pend, fault_pend_n;

    entry_t         fifo_q [DEPTH];
    logic [PW-1:0]  rd_ptr, wr_ptr;
    logic [CW-1:0]  count;

    logic           full;
    logic           req_fire;
    logic           pop;
    logic           push;
    logic           flush;
    logic           busy;
    entry_t         push_entry;
    entry_t         head;

    assign full     = (count == CW'(DEPTH));
    assign req_fire = imem.req_valid && imem.req_ready;
    assign pop      = out_valid && out_ready;

    // The request gate uses registered state only.
    // Occupancy can only fall while in REQ, so a raised valid cannot drop.
    assign imem.req_valid = ((state == S_REQ) && !full) || ((state == S_DROP) && hold);
    assign imem.req_addr  = hold ? hold_addr : fetch_pc;

    // All head outputs come from registers. When the FIFO is empty they read as zero.
    assign head           = fifo_q[rd_ptr];
    assign out_valid      = (count != '0);
    assign out_pc         = out_valid ? head.pc : 32'h0;
    assign out_next_pc    = out_valid ? (head.pc + 32'd4) : 32'h0;
    assign out_instr      = out_valid ? head.instr : 32'h0;
    assign out_misaligned = out_valid && head.misaligned;

    // Next-state and FIFO-push decode; a redirect overrides every normal transition
    always_comb begin
        state_n      = state;
        fetch_pc_n   = fetch_pc;
        hold_n       = hold;
        hold_addr_n  = hold_addr;
        fault_pend_n = fault_pend;
        push         = 1'b0;
        push_entry   = '0;
        flush        = 1'b0;
        busy         = 1'b0;

        case (state)
            S_IDLE: state_n = S_REQ;
            S_REQ: begin
                if (req_fire) begin
                    state_n    = S_WAIT;
                    fetch_pc_n = fetch_pc + 32'd4;
                end
            end
            S_WAIT: begin
                if (imem.rsp_valid) begin
                    push       = 1'b1;
                    push_entry = '{pc: fetch_pc - 32'd4, instr: imem.rsp_data, misaligned: 1'b0};
                    state_n    = S_REQ;
                end
            end
            S_DROP: begin
                if (hold) begin
                    if (imem.req_ready) hold_n = 1'b0;
                end else if (imem.rsp_valid) begin
                    state_n      = fault_pend ? S_FAULT : S_REQ;
                    fault_pend_n = 1'b0;
                end
            end
            S_FAULT: state_n = S_FAULT;
            default: state_n = S_IDLE;
        endcase

        if (br_taken) begin
            // A response is still owed if one is in flight and not arriving this
            // cycle, or if a request is on the bus (accepted now or held for later).
            busy = ((state == S_WAIT) && !imem.rsp_valid) ||
                   ((state == S_DROP) && (hold || !imem.rsp_valid)) ||
                   ((state == S_REQ) && imem.req_valid);

            flush      = 1'b1;
            push       = 1'b0;
            push_entry = '0;
            fetch_pc_n = br_addr;

            if ((state == S_REQ) && imem.req_valid && !imem.req_ready) begin
                hold_n      = 1'b1;
                hold_addr_n = fetch_pc;
            end

            if (br_addr[1:0] == 2'b00) begin
                state_n      = busy ? S_DROP : S_REQ;
                fault_pend_n = 1'b0;
            end else begin
                push         = 1'b1;
                push_entry   = '{pc: br_addr, instr: NOP_INSTR, misaligned: 1'b1};
                state_n      = busy ? S_DROP : S_FAULT;
                fault_pend_n = busy;
            end
        end
    end

    // Control state: FSM, fetch PC, held request and pending-fault flag
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= S_IDLE;
            fetch_pc   <= RESET_PC;
            hold       <= 1'b0;
            hold_addr  <= 32'h0;
            fault_pend <= 1'b0;
        end else begin
            state      <= state_n;
            fetch_pc   <= fetch_pc_n;
            hold       <= hold_n;
            hold_addr  <= hold_addr_n;
            fault_pend <= fault_pend_n;
        end
    end

    // Instruction FIFO. A flush empties it; a fault marker pushed in the same
    // cycle lands in slot 0 of the emptied FIFO.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= PW'(push);
            count  <= CW'(push);
            if (push) fifo_q[0] <= push_entry;
        end else begin
            if (push) begin
                fifo_q[wr_ptr] <= push_entry;
                wr_ptr         <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end
endmodule

// File: tb/tb_tiny_rv_fetch.sv
// Randomized bench for tiny_rv_fetch.
// A small memory model answers each accepted request. The reference model
// tracks, at the level of the architecture:
//   - the next PC decode should see,
//   - the next address fetch should request,
//   - whether fetch sits in a fault after a misaligned redirect.
module tb_tiny_rv_fetch;
    localparam logic [31:0] RPC = 32'h0000_0100;
    localparam int          DEP = 2;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        br_taken = 1'b0;
    logic [31:0] br_addr = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc, out_next_pc, out_instr;
    logic        out_misaligned;

    tiny_rv_fetch_if imem();

    tiny_rv_fetch #(.RESET_PC(RPC), .DEPTH(DEP)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .imem(imem),
        .br_taken(br_taken), .br_addr(br_addr),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_next_pc(out_next_pc),
        .out_instr(out_instr), .out_misaligned(out_misaligned)
    );

    always #5 i_clk = ~i_clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Memory contents are a fixed function of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    // Model state
    localparam int M_RUN = 0, M_FENT = 1, M_FIDLE = 2;
    int          mode;
    logic [31:0] exp_pc, next_req, fault_addr;
    bit          held;
    bit          mem_busy;
    logic [31:0] mem_addr;
    int          mem_lat;
    bit          prev_pend;
    logic [31:0] prev_addr;
    bit          flush_chk, fault_chk, just_rst;
    int          n_pop, n_hs;

    // Knobs
    int  k_rdy = 100, k_ordy = 100, k_br = 0, k_lat = 0, k_mis = 0;
    bit  f_br = 0;
    logic [31:0] f_addr = 32'h0;

    task automatic model_reset();
        mode      = M_RUN;
        exp_pc    = RPC;
        next_req  = RPC;
        held      = 0;
        mem_busy  = 0;
        prev_pend = 0;
        flush_chk = 0;
        fault_chk = 0;
    endtask

    task automatic step();
        logic [31:0] t;
        bit          hs, rsp_now;
        @(negedge i_clk);

        // Checks on the registered state left by the last edge
        if (just_rst) begin
            chk("req_after_rst", imem.req_valid, 1);
            chk("req_addr_after_rst", imem.req_addr, RPC);
            just_rst = 0;
        end
        if (prev_pend) begin
            chk("req_valid_stable", imem.req_valid, 1);
            chk("req_addr_stable", imem.req_addr, prev_addr);
        end
        if (flush_chk) chk("flush_empty", out_valid, 0);
        if (fault_chk) begin
            chk("fault_visible", out_valid, 1);
            chk("fault_mis", out_misaligned, 1);
        end
        flush_chk = 0;
        fault_chk = 0;
        if (mode == M_FIDLE) chk("fault_idle_empty", out_valid, 0);

        // Memory response channel
        imem.rsp_valid = 1'b0;
        if (mem_busy) begin
            if (mem_lat == 0) begin
                imem.rsp_valid = 1'b1;
                imem.rsp_data  = mem_word(mem_addr);
                mem_busy       = 0;
            end else begin
                mem_lat--;
            end
        end
        rsp_now = imem.rsp_valid;

        // Random inputs for the coming edge
        out_ready      = ($urandom_range(0, 99) < k_ordy);
        imem.req_ready = ($urandom_range(0, 99) < k_rdy);
        if (f_br) begin
            br_taken = 1'b1;
            br_addr  = f_addr;
            f_br     = 0;
        end else begin
            br_taken = ($urandom_range(0, 99) < k_br);
            t        = $urandom;
            t[31:16] = ($urandom_range(0, 19) == 0) ? 16'hFFFF : 16'h0000;
            t[1:0]   = ($urandom_range(0, 99) < k_mis) ? 2'($urandom_range(1, 3)) : 2'b00;
            br_addr  = t;
        end

        // Decode consumes the head this edge
        if (out_valid && out_ready) begin
            n_pop++;
            if (mode == M_RUN) begin
                chk("out_pc", out_pc, exp_pc);
                chk("out_next_pc", out_next_pc, exp_pc + 32'd4);
                chk("out_instr", out_instr, mem_word(exp_pc));
                chk("out_mis", out_misaligned, 0);
                exp_pc = exp_pc + 32'd4;
            end else if (mode == M_FENT) begin
                chk("fault_pc", out_pc, fault_addr);
                chk("fault_next_pc", out_next_pc, fault_addr + 32'd4);
                chk("fault_instr", out_instr, 32'h0000_0013);
                chk("fault_mis_pop", out_misaligned, 1);
                mode = M_FIDLE;
            end
        end

        // Request handshake this edge
        hs = imem.req_valid && imem.req_ready;
        if (hs) begin
            chk("one_outstanding", {31'b0, mem_busy | rsp_now}, 0);
            if (held) begin
                held = 0;
            end else if (mode != M_RUN) begin
                chk("req_in_fault", {31'b0, hs}, 0);
            end else begin
                chk("req_addr", imem.req_addr, next_req);
                next_req = next_req + 32'd4;
                n_hs++;
            end
            mem_busy = 1;
            mem_addr = imem.req_addr;
            mem_lat  = $urandom_range(0, k_lat);
        end
        prev_pend = imem.req_valid && !imem.req_ready;
        prev_addr = imem.req_addr;

        // Redirect this edge
        if (br_taken) begin
            if (imem.req_valid && !imem.req_ready) held = 1;
            if (br_addr[1:0] == 2'b00) begin
                mode      = M_RUN;
                exp_pc    = br_addr;
                next_req  = br_addr;
                flush_chk = 1;
            end else begin
                mode       = M_FENT;
                fault_addr = br_addr;
                fault_chk  = 1;
            end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic redirect(input logic [31:0] a);
        f_br   = 1;
        f_addr = a;
        step();
    endtask

    initial begin
        imem.req_ready = 1'b0;
        imem.rsp_valid = 1'b0;
        imem.rsp_data  = 32'h0;
        model_reset();
        n_pop = 0;
        n_hs  = 0;
        just_rst = 0;

        // State while reset is held
        #12;
        chk("rst_req_valid", imem.req_valid, 0);
        chk("rst_req_addr", imem.req_addr, RPC);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_pc", out_pc, 0);
        chk("rst_out_next_pc", out_next_pc, 0);
        chk("rst_out_instr", out_instr, 0);
        chk("rst_out_mis", out_misaligned, 0);
        @(negedge i_clk);
        i_rst    = 1'b0;
        just_rst = 1;

        // Steady stream with single-cycle memory: one instruction every 2 cycles
        k_rdy = 100; k_ordy = 100; k_br = 0; k_lat = 0; k_mis = 0;
        run(10);
        n_pop = 0;
        run(40);
        chk("throughput", n_pop, 20);

        // Back-pressure: only DEPTH requests may issue, then fetch resumes in order
        k_ordy = 0;
        redirect(32'h0000_0400);
        n_hs = 0;
        run(16);
        chk("bp_reqs", n_hs, DEP);
        chk("bp_stall", imem.req_valid, 0);
        chk("bp_full", out_valid, 1);
        k_ordy = 100;
        run(20);
        chk("bp_resume", {31'b0, exp_pc > 32'h0000_0408}, 1);

        // Redirect with a slower memory, so the dropped response arrives later
        k_lat = 2;
        run(3);
        redirect(32'h0000_0200);
        run(20);
        k_lat = 0;

        // Address wrap
        redirect(32'hFFFF_FFF8);
        run(20);
        chk("wrap_seen", {31'b0, exp_pc < 32'h0000_0100}, 1);

        // Misaligned target, then recovery
        redirect(32'h0000_0202);
        run(10);
        chk("fault_seen", mode, M_FIDLE);
        redirect(32'h0000_0300);
        run(12);
        chk("fault_resume", {31'b0, exp_pc > 32'h0000_0300}, 1);

        // Random mix of everything
        k_rdy = 70; k_ordy = 60; k_br = 6; k_lat = 3; k_mis = 20;
        run(3000);

        // Asynchronous reset while a response is owed
        k_br = 0; k_mis = 0;
        begin
            int b = 0;
            while (!mem_busy && b < 50) begin
                step();
                b++;
            end
        end
        chk("rst_found_wait", mem_busy, 1);
        br_taken       = 1'b0;
        imem.rsp_valid = 1'b0;
        i_rst          = 1'b1;
        #1;
        chk("mid_rst_req_valid", imem.req_valid, 0);
        chk("mid_rst_req_addr", imem.req_addr, RPC);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_out_pc", out_pc, 0);
        chk("mid_rst_out_next_pc", out_next_pc, 0);
        chk("mid_rst_out_instr", out_instr, 0);
        model_reset();
        @(negedge i_clk);
        i_rst    = 1'b0;
        just_rst = 1;
        k_br     = 4; k_mis = 10;
        run(300);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
